// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit multiplexed seven-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    typedef enum logic [2:0] {
        StOn0  = 3'd0,
        StGap0 = 3'd1,
        StOn1  = 3'd2,
        StGap1 = 3'd3,
        StOn2  = 3'd4,
        StGap2 = 3'd5,
        StOn3  = 3'd6,
        StGap3 = 3'd7
    } scan_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_UP    = 7'b1100011;
    localparam logic [6:0] SEG_DOWN  = 7'b0100001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Decoder codes beyond the hex range
    localparam logic [4:0] CODE_UP    = 5'd16;
    localparam logic [4:0] CODE_DOWN  = 5'd17;
    localparam logic [4:0] CODE_BLANK = 5'd31;

endpackage

// File: rtl/seg7_decode.sv
// Code to segment-pattern decoder: 0-15 hex, 16 'u', 17 'd', anything else blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            5'd0:      pattern = SEG_0;
            5'd1:      pattern = SEG_1;
            5'd2:      pattern = SEG_2;
            5'd3:      pattern = SEG_3;
            5'd4:      pattern = SEG_4;
            5'd5:      pattern = SEG_5;
            5'd6:      pattern = SEG_6;
            5'd7:      pattern = SEG_7;
            5'd8:      pattern = SEG_8;
            5'd9:      pattern = SEG_9;
            5'd10:     pattern = SEG_A;
            5'd11:     pattern = SEG_B;
            5'd12:     pattern = SEG_C;
            5'd13:     pattern = SEG_D;
            5'd14:     pattern = SEG_E;
            5'd15:     pattern = SEG_F;
            CODE_UP:   pattern = SEG_UP;
            CODE_DOWN: pattern = SEG_DOWN;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Scans a 4-bit value onto a 4-digit common-anode display: tens, ones, hex, direction glyph.
// Define LEADING_ZERO_BLANK_EN to blank the tens digit for values below 10.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    input  logic       value_valid,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam scan_state_e FRAME_END = (BLANK_CYCLES == 0) ? StOn3 : StGap3;

    // state/cnt name the slot position whose outputs are loaded at the next edge
    scan_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       shadow;
    logic [3:0]       disp;
    logic [4:0]       glyph;

    logic             is_gap;
    logic [1:0]       digit;
    logic             slot_last;
    logic             frame_last;
    logic [2:0]       state_step;
    scan_state_e      state_n;
    logic [3:0]       disp_d;
    logic [4:0]       glyph_d;
    logic             tens;
    logic [3:0]       ones;
    logic [4:0]       code;
    logic [6:0]       pattern;
    logic [3:0]       an_d;
    logic [6:0]       seg_d;

    always_comb begin
        is_gap     = state[0];
        digit      = state[2:1];
        slot_last  = is_gap ? (cnt == GAP_LAST) : (cnt == ON_LAST);
        frame_last = slot_last && (state == FRAME_END);
        state_step = (!is_gap && BLANK_CYCLES == 0) ? 3'd2 : 3'd1;
        state_n    = slot_last ? scan_state_e'(3'(state) + state_step) : state;
    end

    // frame_tick marks the boundary cycle; a strobe on it bypasses shadow
    always_comb begin
        disp_d  = disp;
        glyph_d = glyph;
        if (frame_tick) begin
            disp_d = value_valid ? value : shadow;
            if (disp_d > disp) begin
                glyph_d = CODE_UP;
            end else if (disp_d < disp) begin
                glyph_d = CODE_DOWN;
            end
        end
    end

    always_comb begin
        tens = (disp_d >= 4'd10);
        ones = tens ? (disp_d - 4'd10) : disp_d;
        code = CODE_BLANK;
        case (digit)
            2'd0: code = {1'b0, ones};
            2'd1: begin
                if (tens) begin
                    code = 5'd1;
                end else begin
`ifdef LEADING_ZERO_BLANK_EN
                    code = CODE_BLANK;
`else
                    code = 5'd0;
`endif
                end
            end
            2'd2: code = {1'b0, disp_d};
            default: code = glyph_d;
        endcase
    end

    seg7_decode u_decode (
        .code    (code),
        .pattern (pattern)
    );

    always_comb begin
        an_d  = is_gap ? AN_OFF : ~(4'b0001 << digit);
        seg_d = is_gap ? SEG_BLANK : pattern;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StOn0;
            cnt        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_tick <= 1'b0;
            shadow     <= 4'd0;
            disp       <= 4'd0;
            glyph      <= CODE_BLANK;
        end else begin
            state      <= state_n;
            cnt        <= slot_last ? '0 : cnt + CNT_W'(1);
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= frame_last;
            disp       <= disp_d;
            glyph      <= glyph_d;
            if (value_valid) begin
                shadow <= value;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: directed frame tables plus randomized traffic
// against a frame-position reference model.
module tb_seg7_scan_display;

    localparam int RD    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = 4 * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] D1_LOW = 7'b1111111;
`else
    localparam logic [6:0] D1_LOW = 7'b1000000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] value = 4'd0;
    logic       value_valid = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    always #5 clk = ~clk;

    seg7_scan_display #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .seg         (seg),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the frame, plus displayed/pending values
    bit m_valid = 0;
    int m_pos = -1;
    int m_shadow = 0;
    int m_disp = 0;
    int m_glyph = 0;  // 0 blank, 1 up, 2 down

    typedef struct {
        logic [3:0] value;
        logic [6:0] d0;
        logic [6:0] d1;
        logic [6:0] d2;
        logic [6:0] d3;
    } vec_t;

    vec_t tbl[5];

    function automatic logic [6:0] pat(int c);
        case (c)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  15: return 7'b0001110;
            16: return 7'b1100011;  17: return 7'b0100001;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(int slot);
        case (slot)
            0: return pat(m_disp % 10);
            1: return (m_disp >= 10) ? pat(1) : D1_LOW;
            2: return pat(m_disp);
            default: return pat(m_glyph == 1 ? 16 : (m_glyph == 2 ? 17 : 31));
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit r;
        bit v;
        int val;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        r = rst;
        v = value_valid;
        val = int'(value);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1;
            m_pos = -1;
            m_shadow = 0;
            m_disp = 0;
            m_glyph = 0;
        end else begin
            if (m_pos == FRAME - 1) begin
                int nv;
                nv = v ? val : m_shadow;
                if (nv > m_disp) m_glyph = 1;
                else if (nv < m_disp) m_glyph = 2;
                m_disp = nv;
            end
            if (v) m_shadow = val;
            m_pos = (m_pos + 1) % FRAME;
        end
        if (m_valid) begin
            if (m_pos < 0) begin
                e_an = 4'b1111;
                e_seg = 7'b1111111;
                e_ft = 1'b0;
            end else begin
                e_ft = (m_pos == FRAME - 1);
                if ((m_pos % SLOT) >= RD) begin
                    e_an = 4'b1111;
                    e_seg = 7'b1111111;
                end else begin
                    e_an = ~(4'b0001 << (m_pos / SLOT));
                    e_seg = exp_digit(m_pos / SLOT);
                end
            end
            check("model_an", {3'b000, an}, {3'b000, e_an});
            check("model_seg", seg, e_seg);
            check("model_frame_tick", {6'b0, frame_tick}, {6'b0, e_ft});
        end
    endtask

    task automatic strobe(input logic [3:0] v);
        value = v;
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    task automatic run_to_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 2 * FRAME) begin
            step();
            n++;
        end
        if (frame_tick !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_tick_timeout: got %b, expected 1 within %0d cycles",
                     frame_tick, 2 * FRAME);
        end
    endtask

    // Call on the boundary cycle; samples the first cycle of each ON slot, ends on the next boundary
    task automatic capture_frame(output logic [3:0][6:0] d);
        step();
        d[0] = seg;
        repeat (SLOT) step();
        d[1] = seg;
        repeat (SLOT) step();
        d[2] = seg;
        repeat (SLOT) step();
        d[3] = seg;
        repeat (SLOT - 1) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][6:0] d;

        tbl[0] = '{4'd15, 7'b0010010, 7'b1111001, 7'b0001110, 7'b1100011};
        tbl[1] = '{4'd14, 7'b0011001, 7'b1111001, 7'b0000110, 7'b0100001};
        tbl[2] = '{4'd7,  7'b1111000, D1_LOW,     7'b1111000, 7'b0100001};
        tbl[3] = '{4'd9,  7'b0010000, D1_LOW,     7'b0010000, 7'b1100011};
        tbl[4] = '{4'd9,  7'b0010000, D1_LOW,     7'b0010000, 7'b1100011};

        rst = 1'b1;
        repeat (3) begin
            step();
            check("reset_an", {3'b000, an}, 7'b0001111);
            check("reset_seg", seg, 7'b1111111);
        end
        rst = 1'b0;
        step();
        check("first_an", {3'b000, an}, 7'b0001110);
        check("first_seg", seg, 7'b1000000);
        repeat (FRAME - 1) step();
        check("first_frame_tick", {6'b0, frame_tick}, 7'd1);
        repeat (FRAME) step();
        check("second_frame_tick", {6'b0, frame_tick}, 7'd1);

        for (int i = 0; i < 5; i++) begin
            repeat (8) step();
            strobe(tbl[i].value);
            run_to_tick();
            capture_frame(d);
            check($sformatf("tbl%0d_d0", i), d[0], tbl[i].d0);
            check($sformatf("tbl%0d_d1", i), d[1], tbl[i].d1);
            check($sformatf("tbl%0d_d2", i), d[2], tbl[i].d2);
            check($sformatf("tbl%0d_d3", i), d[3], tbl[i].d3);
        end

        // Two strobes in one frame: the later one wins
        repeat (8) step();
        strobe(4'd14);
        run_to_tick();
        capture_frame(d);
        repeat (3) step();
        strobe(4'd3);
        repeat (4) step();
        strobe(4'd10);
        run_to_tick();
        capture_frame(d);
        check("last_wins_d0", d[0], 7'b1000000);
        check("last_wins_d1", d[1], 7'b1111001);
        check("last_wins_d2", d[2], 7'b0001000);
        check("last_wins_d3", d[3], 7'b0100001);

        // Strobe on the boundary cycle shows in the very next ON0
        check("at_boundary", {6'b0, frame_tick}, 7'd1);
        strobe(4'd4);
        check("bypass_an", {3'b000, an}, 7'b0001110);
        check("bypass_seg", seg, 7'b0011001);

        // Reset in the middle of ON2
        repeat (2 * SLOT) step();
        check("on2_an", {3'b000, an}, 7'b0001011);
        rst = 1'b1;
        step();
        check("midrst_an", {3'b000, an}, 7'b0001111);
        check("midrst_seg", seg, 7'b1111111);
        rst = 1'b0;
        step();
        check("postrst_an", {3'b000, an}, 7'b0001110);
        check("postrst_seg", seg, 7'b1000000);
        repeat (3 * SLOT) step();
        check("postrst_glyph_an", {3'b000, an}, 7'b0000111);
        check("postrst_glyph_seg", seg, 7'b1111111);

        run_to_tick();
        repeat (8) step();
        strobe(4'd7);
        run_to_tick();
        capture_frame(d);
        check("seven_d0", d[0], 7'b1111000);
        check("seven_d1", d[1], D1_LOW);

        // Randomized traffic against the model
        for (int i = 0; i < 1200; i++) begin
            value = 4'($urandom_range(0, 15));
            value_valid = ($urandom_range(0, 5) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        value_valid = 1'b0;
        repeat (FRAME) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
